// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit between the register file
// read ports and the writeback mux.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous kill of any in-flight/pending op
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_funct3           RV32M op select
//   in_a, in_b          rs1 / rs2 values
//   in_rd               destination index
//   wb_valid/wb_ready   writeback handshake (wb_valid high only in DONE)
//   wb_rd, wb_data      writeback address / data
//   busy                state is not IDLE
//
// state  | meaning
// IDLE   | waiting for a request
// BUSY   | 32 shift-add / restoring-divide iterations
// DONE   | result held on writeback port until wb_ready or flush

module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] opb_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;

  // Accept-time decode: the datapath always works on magnitudes and the
  // sign is reapplied once to the final value.
  logic        is_div_in, sgn_a_in, sgn_b_in, a_neg_in, b_neg_in, neg_in;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, fast_in;
  logic [31:0] fast_res;

  always_comb begin
    is_div_in = in_funct3[2];
    sgn_a_in  = (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
    sgn_b_in  = (in_funct3 == 3'b001) || (in_funct3 == 3'b100) ||
                (in_funct3 == 3'b110);
    a_neg_in  = sgn_a_in && in_a[31];
    b_neg_in  = sgn_b_in && in_b[31];
    a_mag     = a_neg_in ? (32'd0 - in_a) : in_a;
    b_mag     = b_neg_in ? (32'd0 - in_b) : in_b;
    // Remainder follows the dividend sign only; everything else is a xor.
    neg_in    = (is_div_in && in_funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

    div_zero  = is_div_in && (in_b == 32'd0);
    div_ovf   = is_div_in && !in_funct3[0] &&
                (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
    fast_in   = div_zero || div_ovf;
    if (div_zero) fast_res = in_funct3[1] ? in_a : 32'hFFFF_FFFF;
    else          fast_res = in_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration. Multiply: {hi,lo} shifts right, hi accumulates opb.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [32:0] mul_sum;
  logic [32:0] r_sh;
  logic        r_ge;
  logic [31:0] r_sub;
  logic [31:0] hi_d, lo_d;
  logic [63:0] val64, res64;
  logic [31:0] result;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    r_sh    = {hi_q, lo_q[31]};
    r_ge    = (r_sh >= {1'b0, opb_q});
    // When r_ge holds the true difference fits in 32 bits.
    r_sub   = r_sh[31:0] - opb_q;
    if (op_q[2]) begin
      hi_d = r_ge ? r_sub : r_sh[31:0];
      lo_d = {lo_q[30:0], r_ge};
    end else begin
      hi_d = mul_sum[32:1];
      lo_d = {mul_sum[0], lo_q[31:1]};
    end
    val64  = op_q[2] ? {32'd0, (op_q[1] ? hi_d : lo_d)} : {hi_d, lo_d};
    res64  = neg_q ? (64'd0 - val64) : val64;
    result = (op_q[2] || (op_q[1:0] == 2'b00)) ? res64[31:0] : res64[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= 5'd0;
      op_q      <= 3'd0;
      neg_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      opb_q     <= 32'd0;
      wb_data_q <= 32'd0;
      wb_rd_q   <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && !flush) begin
            op_q    <= in_funct3;
            wb_rd_q <= in_rd;
            if (fast_in) begin
              wb_data_q <= fast_res;
              state_q   <= S_DONE;
            end else begin
              hi_q    <= 32'd0;
              lo_q    <= a_mag;
              opb_q   <= b_mag;
              neg_q   <= neg_in;
              count_q <= 5'd0;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) begin
              wb_data_q <= result;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (flush || wb_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_DONE);
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_funct3(in_funct3), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (called #1 after a rising edge), scramble the
  // operand inputs after accept, then wait for wb_valid and check latency,
  // data and rd. Leaves the unit in DONE.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    in_funct3 = f3; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = b ^ 32'h1234_5678; in_rd = ~rd; in_funct3 = ~f3;
    lat = 0;
    while (!wb_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
  endtask

  task automatic handshake(input string tag);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk({tag, "_hs_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_hs_valid"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    bit seen_valid;
    #12;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 32);
    handshake("mul");
    issue("mulh", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 32);
    handshake("mulh");
    issue("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 32);
    handshake("mulhsu");
    issue("mulhu", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h7FFF_FFFF, 32);
    handshake("mulhu");
    issue("mulh_neg", 3'b001, 32'hFFFF_FFFF, 32'd5, 5'd7, 32'hFFFF_FFFF, 32);
    handshake("mulh_neg");
    issue("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 32);
    handshake("div");
    issue("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 32);
    handshake("rem");
    issue("divu", 3'b101, 32'hFFFF_FFFF, 32'h10, 5'd10, 32'h0FFF_FFFF, 32);
    handshake("divu");
    issue("div_negb", 3'b100, 32'd20, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFA, 32);
    handshake("div_negb");
    issue("rem_negb", 3'b110, 32'd20, 32'hFFFF_FFFD, 5'd12, 32'd2, 32);
    handshake("rem_negb");
    issue("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 32);
    handshake("remu");
    issue("divu_z", 3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 0);
    handshake("divu_z");
    issue("remu_z", 3'b111, 32'd5, 32'd0, 5'd15, 32'd5, 0);
    handshake("remu_z");
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0);
    handshake("div_ovf");
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 0);
    handshake("rem_ovf");
    issue("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 32);
    handshake("mul_rd0");

    // Hold in DONE with wb_ready low and a competing request.
    issue("hold", 3'b000, 32'd3, 32'd5, 5'd9, 32'd15, 32);
    in_valid = 1'b1; in_funct3 = 3'b000; in_a = 32'd2; in_b = 32'd2; in_rd = 5'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("hold_data", wb_data, 32'd15);
      chk("hold_rd", {27'd0, wb_rd}, 32'd9);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handshake("hold");
    issue("after_hold", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, 32);
    handshake("after_hold");

    // Flush at iteration 15.
    in_funct3 = 3'b000; in_a = 32'd9; in_b = 32'd9; in_rd = 5'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (wb_valid) seen_valid = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wb_valid) seen_valid = 1'b1;
    end
    chk("flush_no_wb", {31'd0, seen_valid}, 32'd0);

    // Flush concurrent with a request in IDLE.
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'b101; in_a = 32'd1; in_b = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_busy", {31'd0, busy}, 32'd0);
    chk("flush_acc_valid", {31'd0, wb_valid}, 32'd0);

    // Async reset while in DONE.
    issue("pre_rst", 3'b101, 32'd5, 32'd0, 5'd21, 32'hFFFF_FFFF, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_done_data", wb_data, 32'd0);
    chk("rst_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit that sits directly downstream of the integer register file. It takes the two source values read from the file, the funct3 operation code and the destination index. It computes the RV32M result over 32 iterations, or in one cycle for divide special cases. It presents the result on a writeback port that drives the register file's write-enable, write-address and write-data inputs through the writeback mux.

## Interface
- No parameters; the datapath is fixed at 32 bits and the iteration count at 32.

- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill; abandons any in-flight or pending op.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high exactly when the state is IDLE.
- in_funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  input  32  rs1 value, taken from register-file rv1.
- in_b  input  32  rs2 value, taken from register-file rv2.
- in_rd  input  5  destination register index.
- wb_valid  output  1  result available; high exactly in DONE.
- wb_ready  input  1  writeback port grants this unit.
- wb_rd  output  5  destination index, captured at accept.
- wb_data  output  32  result.
- busy  output  1  state is not IDLE.

## Operation
- States are IDLE, BUSY and DONE. Reset (rst_n low) forces IDLE asynchronously and clears the counter. Reset values: wb_valid=0, wb_rd=0, wb_data=0, busy=0, in_ready=1.
- Accept happens on the rising edge where in_valid && in_ready && !flush. At that edge the unit latches funct3, in_a, in_b and in_rd.
  - Normal ops go to BUSY with count=0.
  - Fast-path ops go directly to DONE with the result loaded.
- Fast paths, both decided at accept:
  - Divide by zero (in_b==0, any DIV/DIVU/REM/REMU): the quotient is 0xFFFFFFFF and the remainder is in_a.
  - Signed overflow (DIV/REM, in_a==0x80000000, in_b==0xFFFFFFFF): DIV gives 0x80000000 and REM gives 0.
- BUSY performs one iteration per edge and increments count.
  - On the edge where count==31 the final iteration executes, the result is loaded into wb_data, and the state becomes DONE.
  - Any internal algorithm is allowed (shift-add, restoring or non-restoring division), provided it uses exactly 32 iterations and yields the results below.
- Multiply results:
  - MUL returns the low 32 bits of the 64-bit product.
  - MULH returns the high 32 bits for signed×signed.
  - MULHSU returns the high 32 bits for signed in_a × unsigned in_b.
  - MULHU returns the high 32 bits for unsigned×unsigned.
- Divide results:
  - DIV and DIVU truncate toward zero.
  - REM and REMU take the sign of the dividend.
  - Signed ops handle the negative magnitude 0x80000000 correctly.
- DONE holds wb_valid, wb_rd and wb_data stable until a handshake. The handshake is the edge with wb_valid && wb_ready, after which the state returns to IDLE.
- in_rd==0 is computed and delivered normally; the register file discards the write.
- Flush has priority over accept, iteration and handshake. On a flush edge the state returns to IDLE and wb_valid deasserts; no writeback occurs. wb_data and wb_rd may hold stale values.

## Timing
- Normal op latency: wb_valid rises 32 edges after the accepting edge (iterations on edges E1..E32), so the result is visible in the cycle after E32.
- Fast path latency: wb_valid is high in the cycle right after the accepting edge.
- Throughput: a new accept is possible at the earliest on the edge after the handshake edge, because in_ready is low throughout DONE. A normal op therefore has a minimum issue interval of 34 cycles.
- in_ready and busy are combinational from state only. in_ready has no combinational path from in_valid or wb_ready.
- Reset deasserted mid-BUSY or mid-DONE leaves the unit in IDLE with no pending writeback.
- Operand inputs may change after accept without affecting the result.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) gives wb_data=0xFFFFFFEB, with wb_valid exactly 32 edges after accept and wb_rd equal to the accepted in_rd.
- MULH, MULHSU and MULHU with a=0x80000000, b=0xFFFFFFFF give 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- DIV −7/2 gives 0xFFFFFFFD, and REM −7/2 gives 0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 gives 0x0FFFFFFF.
- Fast paths:
  - DIVU 5/0 gives 0xFFFFFFFF one cycle after accept, and REMU 5/0 gives 5.
  - DIV 0x80000000/−1 gives 0x80000000, and REM gives 0, also one cycle after accept.
- Hold wb_ready=0 for 10 cycles in DONE: wb_valid, wb_rd and wb_data stay stable and in_ready stays 0 even with in_valid high. Then pulse wb_ready: the state is IDLE the next cycle and a new op is accepted.
- Flush at iteration 15 goes to IDLE with wb_valid never asserted. Flush concurrent with in_valid in IDLE accepts nothing. rst_n asserted in DONE sets wb_valid=0 immediately, asynchronously.
